key_matrix_scanner: RTL and testbench

- Board-side receiver for the 4x4 button matrix on the fpga_top GPIO pins btn_key_col and btn_key_row.
- Drives one column low at a time, samples the rows, debounces whole-matrix frames and emits one key-press event per clean press.
- Events use a valid/ready handshake toward the CPU-side GPIO register block.
- Ghosting protection: simultaneous multi-key presses are reported as a level flag and never as events.

---
 rtl/kbd_pkg.sv | 69 ++++++
 rtl/sync_2ff.sv | 28 ++
 rtl/key_matrix_scanner.sv | 160 ++++++++++++++++
 tb/tb_key_matrix_scanner.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types and helpers for the 4x4 key matrix scanner
package kbd_pkg;

  localparam int NCOL = 4;
  localparam int NROW = 4;
  localparam int NKEY = NCOL * NROW;

  typedef logic [3:0] key_code_t;
  typedef logic [1:0] col_idx_t;

  // Committed (debounced) matrix state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEY   = 2'd1,
    ST_MULTI = 2'd2
  } kstate_e;

  // Classification of one full scan frame
  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } cls_kind_e;

  // code is only meaningful for CLS_SINGLE and is forced to zero otherwise,
  // so two frames of the same class always compare equal.
  typedef struct packed {
    cls_kind_e kind;
    key_code_t code;
  } frame_cls_t;

  localparam frame_cls_t CLS_IDLE_VAL = '{kind: CLS_NONE, code: 4'd0};

  // Active-low column drive for column c
  function automatic logic [NCOL-1:0] col_drive(input col_idx_t c);
    col_drive = ~(NCOL'(1) << c);
  endfunction

  // pressed[k] = 1 means key k (row*NCOL+col) was seen low in this frame
  function automatic frame_cls_t classify(input logic [NKEY-1:0] pressed);
    int unsigned n;
    frame_cls_t  c;
    n      = 0;
    c.kind = CLS_NONE;
    c.code = '0;
    for (int k = 0; k < NKEY; k++) begin
      if (pressed[k]) begin
        n++;
        c.code = key_code_t'(k);
      end
    end
    if (n == 1) begin
      c.kind = CLS_SINGLE;
    end else if (n > 1) begin
      c.kind = CLS_MULTI;
      c.code = '0;
    end
    classify = c;
  endfunction

  function automatic kstate_e cls_to_state(input cls_kind_e kind);
    case (kind)
      CLS_SINGLE: cls_to_state = ST_KEY;
      CLS_MULTI:  cls_to_state = ST_MULTI;
      default:    cls_to_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized two-flop synchronizer
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of an asynchronous input bus
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - 4x4 key matrix scan, debounce and press-event generator
module key_matrix_scanner
  import kbd_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] btn_key_col,
  input  logic [3:0] btn_key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       key_multi,
  output logic       key_overrun
);

  localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam int                CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_FRAMES);
  localparam col_idx_t          COL_LAST  = col_idx_t'(NCOL - 1);

  // Scan position
  logic [SLOT_W-1:0] slot_q;
  col_idx_t          col_q;
  logic [NCOL-1:0]   col_drv_q;

  // Frame accumulation and debounce
  logic [NROW-1:0]   row_sync;
  logic [NKEY-1:0]   acc_q, acc_d;
  frame_cls_t        prev_q, frame_cls;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Committed state and event register
  kstate_e           st_q, st_new;
  key_code_t         st_key_q;
  key_code_t         key_code_q;
  logic              key_valid_q;
  logic              key_overrun_q;
  logic              key_down_q;
  logic              key_multi_q;

  logic              slot_end;
  logic              frame_end;
  logic              commit;
  logic              press_evt;
  logic              handshake;

  // Rows idle high, so the synchronizer resets to "nothing pressed"
  sync_2ff #(
    .WIDTH     (NROW),
    .RESET_VAL ({NROW{1'b1}})
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_key_row),
    .q_o   (row_sync)
  );

  // Accumulator update, frame classification, debounce count and event decision
  always_comb begin
    slot_end  = (slot_q == SLOT_LAST);
    frame_end = slot_end && (col_q == COL_LAST);

    // The current column's rows are merged in before classifying, so the
    // frame-end cycle sees all 16 samples including column 3.
    acc_d = acc_q;
    for (int c = 0; c < NCOL; c++) begin
      if (col_q == col_idx_t'(c)) begin
        for (int r = 0; r < NROW; r++) begin
          acc_d[r*NCOL + c] = ~row_sync[r];
        end
      end
    end
    frame_cls = classify(acc_d);

    if (frame_cls == prev_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = CNT_W'(1);
    end

    // Committing again while saturated is harmless: events need a state change.
    commit    = frame_end && (cnt_d == CNT_MAX);
    st_new    = cls_to_state(frame_cls.kind);
    press_evt = commit && (st_new == ST_KEY) &&
                ((st_q == ST_IDLE) || ((st_q == ST_KEY) && (st_key_q != frame_cls.code)));
    handshake = key_valid_q && key_ready;
  end

  // Slot counter, column index and registered column drive
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= '0;
      col_q     <= '0;
      col_drv_q <= col_drive(2'd0);
    end else if (slot_end) begin
      slot_q    <= '0;
      col_q     <= (col_q == COL_LAST) ? 2'd0 : col_q + 2'd1;
      col_drv_q <= col_drive((col_q == COL_LAST) ? 2'd0 : col_q + 2'd1);
    end else begin
      slot_q    <= slot_q + SLOT_W'(1);
    end
  end

  // Frame capture, debounce, committed state and single-entry event register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q         <= '0;
      prev_q        <= CLS_IDLE_VAL;
      cnt_q         <= '0;
      st_q          <= ST_IDLE;
      st_key_q      <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_overrun_q <= 1'b0;
      key_down_q    <= 1'b0;
      key_multi_q   <= 1'b0;
    end else begin
      key_overrun_q <= 1'b0;

      if (slot_end) begin
        acc_q <= acc_d;
      end

      if (frame_end) begin
        prev_q <= frame_cls;
        cnt_q  <= cnt_d;
        if (commit) begin
          st_q        <= st_new;
          st_key_q    <= frame_cls.code;
          key_down_q  <= (st_new == ST_KEY);
          key_multi_q <= (st_new == ST_MULTI);
        end
      end

      if (press_evt) begin
        if (!key_valid_q || handshake) begin
          key_code_q  <= frame_cls.code;
          key_valid_q <= 1'b1;
        end else begin
          key_overrun_q <= 1'b1;
        end
      end else if (handshake) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign btn_key_col = col_drv_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_down    = key_down_q;
  assign key_multi   = key_multi_q;
  assign key_overrun = key_overrun_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb/tb_key_matrix_scanner.sv - self-checking bench for key_matrix_scanner
module tb_key_matrix_scanner;

  localparam int SD = 4;
  localparam int DF = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn_key_col;
  logic [3:0]  btn_key_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic        key_down;
  logic        key_multi;
  logic        key_overrun;

  logic [15:0] pressed = 16'h0000;
  int          cyc;
  int          checks;
  int          failures;
  int          ovr_cnt;
  logic [3:0]  exp_q[$];

  key_matrix_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_key_col (btn_key_col),
    .btn_key_row (btn_key_row),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_down    (key_down),
    .key_multi   (key_multi),
    .key_overrun (key_overrun)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    btn_key_row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && !btn_key_col[c]) btn_key_row[r] = 1'b0;
      end
    end
  end

  // Cycle 0 is the first cycle after the last reset edge
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Scoreboard: pop an expected code at every handshake, count overrun pulses
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (key_overrun === 1'b1) ovr_cnt++;
      if (key_valid === 1'b1 && key_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("event_expected", 32'(exp_q.size()), 32'd1);
        else                   chk("event_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) chk("wait_timeout", 32'(cyc), 32'(n));
  endtask

  task automatic do_reset(input logic [15:0] keys);
    @(negedge clk);
    #1;
    reset     = 1'b1;
    key_ready = 1'b0;
    pressed   = '0;
    exp_q.delete();
    ovr_cnt   = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    pressed = keys;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge clk);
    #1 key_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid_clear", 32'(key_valid), 32'd0);
    #1 key_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    checks   = 0;
    failures = 0;
    ovr_cnt  = 0;

    // Column walk with no keys
    do_reset(16'h0000);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_down", 32'(key_down), 32'd0);
    chk("rst_multi", 32'(key_multi), 32'd0);
    chk("rst_overrun", 32'(key_overrun), 32'd0);
    for (int c = 0; c < 32; c++) begin
      wait_cyc(c);
      e = 4'b1111;
      e[(c / 4) % 4] = 1'b0;
      chk("col_walk", 32'(btn_key_col), 32'(e));
    end
    wait_cyc(63);
    chk("idle_valid", 32'(key_valid), 32'd0);
    chk("idle_down", 32'(key_down), 32'd0);
    chk("idle_multi", 32'(key_multi), 32'd0);

    // Single press of key 9 with handshake at cycle 60
    do_reset(16'h0200);
    exp_q.push_back(4'd9);
    wait_cyc(47);
    chk("single_valid_early", 32'(key_valid), 32'd0);
    wait_cyc(48);
    chk("single_valid", 32'(key_valid), 32'd1);
    chk("single_code", 32'(key_code), 32'd9);
    chk("single_down", 32'(key_down), 32'd1);
    wait_cyc(60);
    #1 key_ready = 1'b1;
    wait_cyc(61);
    chk("single_valid_clr", 32'(key_valid), 32'd0);
    wait_cyc(120);
    chk("single_no_repeat", 32'(key_valid), 32'd0);
    chk("single_still_down", 32'(key_down), 32'd1);
    chk("single_sb_empty", 32'(exp_q.size()), 32'd0);
    #1 key_ready = 1'b0;

    // Bounce: 2 frames pressed, 1 released, then held
    do_reset(16'h0200);
    wait_cyc(32);
    #1 pressed = 16'h0000;
    wait_cyc(48);
    chk("bounce_no_evt", 32'(key_valid), 32'd0);
    #1 pressed = 16'h0200;
    exp_q.push_back(4'd9);
    wait_cyc(95);
    chk("bounce_valid_early", 32'(key_valid), 32'd0);
    wait_cyc(96);
    chk("bounce_valid", 32'(key_valid), 32'd1);
    chk("bounce_code", 32'(key_code), 32'd9);
    #1 pressed = 16'h0000;
    wait_cyc(143);
    chk("bounce_down_held", 32'(key_down), 32'd1);
    wait_cyc(144);
    chk("bounce_release", 32'(key_down), 32'd0);
    drain();

    // Ghosting: keys 0 and 5 together
    do_reset(16'h0021);
    wait_cyc(47);
    chk("ghost_multi_early", 32'(key_multi), 32'd0);
    wait_cyc(48);
    chk("ghost_multi", 32'(key_multi), 32'd1);
    chk("ghost_down", 32'(key_down), 32'd0);
    chk("ghost_no_evt", 32'(key_valid), 32'd0);
    wait_cyc(64);
    #1 pressed = 16'h0001;
    wait_cyc(111);
    chk("ghost_multi_held", 32'(key_multi), 32'd1);
    wait_cyc(112);
    chk("ghost_to_key_multi", 32'(key_multi), 32'd0);
    chk("ghost_to_key_down", 32'(key_down), 32'd1);
    chk("ghost_to_key_no_evt", 32'(key_valid), 32'd0);
    #1 pressed = 16'h0000;
    wait_cyc(160);
    chk("ghost_release", 32'(key_down), 32'd0);
    chk("ghost_release_no_evt", 32'(key_valid), 32'd0);
    #1 pressed = 16'h0020;
    exp_q.push_back(4'd5);
    wait_cyc(207);
    chk("ghost_k5_early", 32'(key_valid), 32'd0);
    wait_cyc(208);
    chk("ghost_k5_valid", 32'(key_valid), 32'd1);
    chk("ghost_k5_code", 32'(key_code), 32'd5);
    drain();
    chk("ghost_no_overrun", 32'(ovr_cnt), 32'd0);

    // Overrun: 3 pending, release, then 12 is dropped
    do_reset(16'h0008);
    exp_q.push_back(4'd3);
    wait_cyc(48);
    chk("ovr_first_valid", 32'(key_valid), 32'd1);
    chk("ovr_first_code", 32'(key_code), 32'd3);
    #1 pressed = 16'h0000;
    wait_cyc(96);
    chk("ovr_released", 32'(key_down), 32'd0);
    #1 pressed = 16'h1000;
    wait_cyc(143);
    chk("ovr_pulse_early", 32'(key_overrun), 32'd0);
    wait_cyc(144);
    chk("ovr_pulse", 32'(key_overrun), 32'd1);
    chk("ovr_code_held", 32'(key_code), 32'd3);
    chk("ovr_valid_held", 32'(key_valid), 32'd1);
    chk("ovr_down", 32'(key_down), 32'd1);
    wait_cyc(145);
    chk("ovr_pulse_end", 32'(key_overrun), 32'd0);
    chk("ovr_code_stable", 32'(key_code), 32'd3);
    drain();
    chk("ovr_pulse_count", 32'(ovr_cnt), 32'd1);

    // Reset for one cycle mid-frame with key 9 held
    do_reset(16'h0200);
    wait_cyc(30);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_col", 32'(btn_key_col), 32'hE);
    chk("midrst_valid", 32'(key_valid), 32'd0);
    chk("midrst_code", 32'(key_code), 32'd0);
    chk("midrst_down", 32'(key_down), 32'd0);
    chk("midrst_multi", 32'(key_multi), 32'd0);
    #1 reset = 1'b0;
    exp_q.push_back(4'd9);
    wait_cyc(47);
    chk("midrst_valid_early", 32'(key_valid), 32'd0);
    wait_cyc(48);
    chk("midrst_valid_rise", 32'(key_valid), 32'd1);
    chk("midrst_evt_code", 32'(key_code), 32'd9);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
